// File: rtl/smooth_main_if.sv
// Sample stream bundle between the ADC capture, the smoothing stage and the
// hit detector. The smoothing stage takes the slave side: it consumes raw
// samples and produces the smoothed stream.
interface smooth_main_if;
  logic [15:0] ad_data;
  logic        ad_vld;
  logic [15:0] sm_data;
  logic        sm_vld;

  modport master (
    output ad_data, ad_vld,
    input  sm_data, sm_vld
  );

  modport slave (
    input  ad_data, ad_vld,
    output sm_data, sm_vld
  );
endinterface

// File: rtl/smooth_main.sv
// smooth_main: moving-average smoother over a power-of-two window.
// A ring buffer holds recent samples and a running sum tracks the window
// total. The mean (sum >> log2 W) is registered one cycle later, so a sample
// strobe leads to an output strobe two cycles on.
// Optional feature macro SM_BASELINE_EN: subtract cfg_base from the mean,
// saturating at zero. Without it cfg_base is accepted but unused.
module smooth_main #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  smooth_main_if.slave       sm_if,
  input  logic [2:0]         cfg_win,
  input  logic [15:0]        cfg_base,
  output logic               stu_sm_ready
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = 16 + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;

  logic [15:0]           ring_buf [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]      sum;
  logic [FILL_W-1:0]     fill;
  logic [2:0]            win_q;
  logic                  acc_q;   // accepted sample completed a full window

  logic [2:0]            win_c;
  logic                  flush;
  logic                  accept;
  logic                  full;
  logic [FILL_W-1:0]     w_val;
  logic [FILL_W-1:0]     fill_next;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [15:0]           old;
  logic [SUM_W-1:0]      sum_next;
  logic [15:0]           mean;
  logic [15:0]           out_val;

  // Window clamp, flush detect and the running-sum update for this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    win_c     = cfg_win;
    old       = '0;
    if (int'(cfg_win) > DEPTH_LOG2) win_c = 3'(DEPTH_LOG2);
    flush     = (win_c != win_q);
    accept    = sm_if.ad_vld && !flush;
    w_val     = FILL_W'(1) << win_q;
    full      = (fill == w_val);
    // W == depth wraps to wr_ptr itself: the oldest entry, read before overwrite.
    rd_ptr    = wr_ptr - w_val[DEPTH_LOG2-1:0];
    if (full) old = ring_buf[rd_ptr];
    fill_next = full ? fill : fill + FILL_W'(1);
    sum_next  = sum + SUM_W'(sm_if.ad_data) - SUM_W'(old);
  end

  assign stu_sm_ready = full;

  // Window state: flush on a window change, otherwise absorb accepted samples.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      sum    <= '0;
      fill   <= '0;
      wr_ptr <= '0;
      acc_q  <= 1'b0;
    end else if (flush) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      win_q  <= win_c;
      sum    <= '0;
      fill   <= '0;
      wr_ptr <= '0;
      acc_q  <= 1'b0;
    end else begin
      acc_q <= accept && (fill_next == w_val);
      if (accept) begin
        sum    <= sum_next;
        fill   <= fill_next;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Sample storage; stale entries are masked by the fill gating.
  // NOTE: the memory has no reset so it can map onto RAM; fill makes it safe.
  always_ff @(posedge clk_sys) begin
    if (accept) ring_buf[wr_ptr] <= sm_if.ad_data;
  end

  // Mean and optional baseline removal feeding the output register.
  always_comb begin
    mean    = 16'(sum >> win_q);
    out_val = mean;
`ifdef SM_BASELINE_EN
    out_val = (mean >= cfg_base) ? mean - cfg_base : 16'd0;
`endif
  end

`ifndef SM_BASELINE_EN
  logic unused_cfg_base;
  assign unused_cfg_base = ^cfg_base;
`endif

  // Output stage: one strobe per qualifying sample, data held between strobes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sm_if.sm_data <= '0;
      sm_if.sm_vld  <= 1'b0;
    end else begin
      sm_if.sm_vld <= acc_q;
      if (acc_q) sm_if.sm_data <= out_val;
    end
  end

endmodule

// File: tb/tb_smooth_main.sv
// Directed bench for smooth_main (DEPTH_LOG2 = 4). Inputs are driven 1 time
// unit after the rising edge; a monitor logs every sm_vld strobe with its
// cycle number on the falling edge, and each scenario task compares the log
// against hand-computed means and a 2-cycle drive-to-strobe latency.
module tb_smooth_main;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg_win;
  logic [15:0] cfg_base;
  logic        stu_sm_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          c;
    logic [15:0] d;
  } ev_t;

  ev_t evq[$];

  smooth_main_if u_if();

  smooth_main #(.DEPTH_LOG2(4)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .sm_if        (u_if.slave),
    .cfg_win      (cfg_win),
    .cfg_base     (cfg_base),
    .stu_sm_ready (stu_sm_ready)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    ev_t e;
    if (u_if.sm_vld === 1'b1) begin
      e.c = cyc;
      e.d = u_if.sm_data;
      evq.push_back(e);
    end
  end

  // Present one sample for one cycle; c returns the cycle it was presented in.
  task automatic drive(input logic [15:0] d, output int c);
    c = cyc;
    u_if.ad_vld  = 1'b1;
    u_if.ad_data = d;
    @(posedge clk_sys);
    #1;
    u_if.ad_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    cfg_win      = 3'd0;
    cfg_base     = 16'd0;
    u_if.ad_vld  = 1'b0;
    u_if.ad_data = 16'd0;
    idle(2);
    checks++;
    if (u_if.sm_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_sm_vld: got %b want 0", u_if.sm_vld);
    end
    checks++;
    if (u_if.sm_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_sm_data: got %0d want 0", u_if.sm_data);
    end
    checks++;
    if (stu_sm_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", stu_sm_ready);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_fill();
    int   s[8];
    logic exp_rdy;
    cfg_win = 3'd2;
    idle(1);
    evq.delete();
    for (int i = 0; i < 8; i++) begin
      drive(16'd100, s[i]);
      exp_rdy = (i >= 3);
      checks++;
      if (stu_sm_ready !== exp_rdy) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want %b", i, stu_sm_ready, exp_rdy);
      end
    end
    idle(3);
    checks++;
    if (evq.size() !== 5) begin
      errors++;
      $display("FAIL fill_count: got %0d strobes want 5", evq.size());
    end
    for (int k = 0; k < 5 && k < evq.size(); k++) begin
      checks++;
      if (evq[k].c !== s[k+3] + 2 || evq[k].d !== 16'd100) begin
        errors++;
        $display("FAIL fill_out[%0d]: got cyc %0d data %0d want cyc %0d data 100",
                 k, evq[k].c, evq[k].d, s[k+3] + 2);
      end
    end
  endtask

  task automatic test_ramp();
    int          s[6];
    logic [15:0] exp_d[3] = '{16'd6, 16'd10, 16'd14};
    cfg_win = 3'd0;
    idle(1);
    cfg_win = 3'd2;
    idle(1);
    evq.delete();
    for (int i = 0; i < 6; i++) begin
      drive(16'(i * 4), s[i]);
      idle(1);
    end
    idle(2);
    checks++;
    if (evq.size() !== 3) begin
      errors++;
      $display("FAIL ramp_count: got %0d strobes want 3", evq.size());
    end
    for (int k = 0; k < 3 && k < evq.size(); k++) begin
      checks++;
      if (evq[k].c !== s[k+3] + 2 || evq[k].d !== exp_d[k]) begin
        errors++;
        $display("FAIL ramp_out[%0d]: got cyc %0d data %0d want cyc %0d data %0d",
                 k, evq[k].c, evq[k].d, s[k+3] + 2, exp_d[k]);
      end
    end
    checks++;
    if (u_if.sm_data !== 16'd14) begin
      errors++;
      $display("FAIL ramp_hold: got %0d want 14", u_if.sm_data);
    end
  endtask

  task automatic test_clamp();
    int   s[20];
    logic exp_rdy;
    cfg_win = 3'd7;
    idle(1);
    evq.delete();
    for (int i = 0; i < 20; i++) begin
      drive(16'hFFFF, s[i]);
      exp_rdy = (i >= 15);
      checks++;
      if (stu_sm_ready !== exp_rdy) begin
        errors++;
        $display("FAIL clamp_ready[%0d]: got %b want %b", i, stu_sm_ready, exp_rdy);
      end
    end
    idle(3);
    checks++;
    if (evq.size() !== 5) begin
      errors++;
      $display("FAIL clamp_count: got %0d strobes want 5", evq.size());
    end
    for (int k = 0; k < 5 && k < evq.size(); k++) begin
      checks++;
      if (evq[k].c !== s[k+15] + 2 || evq[k].d !== 16'hFFFF) begin
        errors++;
        $display("FAIL clamp_out[%0d]: got cyc %0d data %h want cyc %0d data ffff",
                 k, evq[k].c, evq[k].d, s[k+15] + 2);
      end
    end
    // 5 also clamps to 4, so the window must not flush.
    cfg_win = 3'd5;
    idle(2);
    checks++;
    if (stu_sm_ready !== 1'b1) begin
      errors++;
      $display("FAIL clamp_noflush: got %b want 1", stu_sm_ready);
    end
  endtask

  task automatic test_window_change();
    int s0, s1, sd, s2, s3;
    cfg_win = 3'd0;
    idle(1);
    evq.delete();
    drive(16'd50, s0);
    checks++;
    if (stu_sm_ready !== 1'b1) begin
      errors++;
      $display("FAIL win1_ready: got %b want 1", stu_sm_ready);
    end
    drive(16'd80, s1);
    cfg_win = 3'd1;
    drive(16'd77, sd);
    checks++;
    if (stu_sm_ready !== 1'b0) begin
      errors++;
      $display("FAIL winchg_ready_drop: got %b want 0", stu_sm_ready);
    end
    drive(16'd60, s2);
    checks++;
    if (stu_sm_ready !== 1'b0) begin
      errors++;
      $display("FAIL winchg_ready_half: got %b want 0", stu_sm_ready);
    end
    drive(16'd60, s3);
    checks++;
    if (stu_sm_ready !== 1'b1) begin
      errors++;
      $display("FAIL winchg_ready_full: got %b want 1", stu_sm_ready);
    end
    idle(3);
    checks++;
    if (evq.size() !== 3) begin
      errors++;
      $display("FAIL winchg_count: got %0d strobes want 3", evq.size());
    end
    if (evq.size() == 3) begin
      checks++;
      if (evq[0].c !== s0 + 2 || evq[0].d !== 16'd50) begin
        errors++;
        $display("FAIL winchg_out0: got cyc %0d data %0d want cyc %0d data 50",
                 evq[0].c, evq[0].d, s0 + 2);
      end
      checks++;
      if (evq[1].c !== s1 + 2 || evq[1].d !== 16'd80) begin
        errors++;
        $display("FAIL winchg_out1: got cyc %0d data %0d want cyc %0d data 80",
                 evq[1].c, evq[1].d, s1 + 2);
      end
      checks++;
      if (evq[2].c !== s3 + 2 || evq[2].d !== 16'd60) begin
        errors++;
        $display("FAIL winchg_out2: got cyc %0d data %0d want cyc %0d data 60",
                 evq[2].c, evq[2].d, s3 + 2);
      end
    end
  endtask

  task automatic test_baseline();
    int          s0, s1;
    logic [15:0] e0, e1;
`ifdef SM_BASELINE_EN
    e0 = 16'd70;
    e1 = 16'd0;
`else
    e0 = 16'd100;
    e1 = 16'd20;
`endif
    cfg_base = 16'd30;
    cfg_win  = 3'd0;
    idle(1);
    evq.delete();
    drive(16'd100, s0);
    drive(16'd20, s1);
    idle(3);
    checks++;
    if (evq.size() !== 2) begin
      errors++;
      $display("FAIL base_count: got %0d strobes want 2", evq.size());
    end
    if (evq.size() == 2) begin
      checks++;
      if (evq[0].c !== s0 + 2 || evq[0].d !== e0) begin
        errors++;
        $display("FAIL base_out0: got cyc %0d data %0d want cyc %0d data %0d",
                 evq[0].c, evq[0].d, s0 + 2, e0);
      end
      checks++;
      if (evq[1].c !== s1 + 2 || evq[1].d !== e1) begin
        errors++;
        $display("FAIL base_out1: got cyc %0d data %0d want cyc %0d data %0d",
                 evq[1].c, evq[1].d, s1 + 2, e1);
      end
    end
    cfg_base = 16'd0;
  endtask

  task automatic test_reset_mid();
    int   s[10];
    int   r[8];
    logic exp_rdy;
    cfg_win = 3'd3;
    idle(1);
    evq.delete();
    for (int i = 0; i < 10; i++) drive(16'((i + 1) * 10), s[i]);
    // Strobe for the 9th sample (window 20..90 -> 55) is on the bus now.
    checks++;
    if (u_if.sm_vld !== 1'b1 || u_if.sm_data !== 16'd55) begin
      errors++;
      $display("FAIL rstmid_pre: got vld %b data %0d want vld 1 data 55",
               u_if.sm_vld, u_if.sm_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.sm_vld !== 1'b0 || u_if.sm_data !== 16'd0 || stu_sm_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got vld %b data %0d ready %b want 0 0 0",
               u_if.sm_vld, u_if.sm_data, stu_sm_ready);
    end
    checks++;
    if (evq.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_pre_count: got %0d strobes want 1", evq.size());
    end else if (evq[0].c !== s[7] + 2 || evq[0].d !== 16'd45) begin
      errors++;
      $display("FAIL rstmid_pre_out: got cyc %0d data %0d want cyc %0d data 45",
               evq[0].c, evq[0].d, s[7] + 2);
    end
    evq.delete();
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      drive(16'd40, r[i]);
      exp_rdy = (i == 7);
      checks++;
      if (stu_sm_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rstmid_ready[%0d]: got %b want %b", i, stu_sm_ready, exp_rdy);
      end
    end
    idle(3);
    checks++;
    if (evq.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_count: got %0d strobes want 1", evq.size());
    end else if (evq[0].c !== r[7] + 2 || evq[0].d !== 16'd40) begin
      errors++;
      $display("FAIL rstmid_out: got cyc %0d data %0d want cyc %0d data 40",
               evq[0].c, evq[0].d, r[7] + 2);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ramp();
    test_clamp();
    test_window_change();
    test_baseline();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smooth_main.md
# smooth_main

Moving-average smoothing stage between the ADC sample capture and the hit detection FSM. Accepts raw 16-bit samples with a valid strobe, keeps a ring buffer of the most recent samples and a running sum, and emits the window mean as `sm_data`/`sm_vld` for the hit detector's threshold compare. Window length is a runtime power of two. Optional baseline subtraction is a compile-time option.

## Interface
- `DEPTH_LOG2`, default 4: log2 of ring buffer depth; maximum window = 2^DEPTH_LOG2 samples.
- `clk_sys`  input  1: system clock; all logic on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `ad_data`  input  16: raw unsigned sample.
- `ad_vld`  input  1: one-cycle strobe, `ad_data` valid. Back-to-back strobes are allowed.
- `cfg_win`  input  3: log2 of window length W. Values above DEPTH_LOG2 clamp to DEPTH_LOG2.
- `cfg_base`  input  16: baseline subtracted from the mean. Used only with `SM_BASELINE_EN`.
- `sm_data`  output  16: smoothed sample, registered.
- `sm_vld`  output  1: one-cycle strobe qualifying `sm_data`.
- `stu_sm_ready`  output  1: window has been filled since the last flush.

## Operation
- **Ring buffer:** `buf[0 .. 2^DEPTH_LOG2-1]` holds 16-bit samples, addressed by `wr_ptr` (DEPTH_LOG2 bits, wraps modulo depth).
- **Running sum:** `sum` is 16+DEPTH_LOG2 bits, unsigned. The sum never overflows at full scale.
- **Window:** W = 2^win_q, where `win_q` is the registered, clamped copy of `cfg_win`.
- **Per accepted `ad_vld`:**
  - `buf[wr_ptr] <= ad_data`.
  - `wr_ptr <= wr_ptr + 1`.
  - `sum <= sum + ad_data - old`, where `old = buf[wr_ptr - W]` (modulo depth) if `fill == W`, else 0.
  - `fill` counter (DEPTH_LOG2+1 bits) increments while `fill < W` and saturates at W.
- **Mean:** `sum >> win_q`, truncated toward zero. It always fits in 16 bits.
- **Output gating:** `sm_vld` is asserted only for samples accepted when the post-update `fill == W`. The first W-1 samples after a flush produce no output.
- **Flush:** when `cfg_win` (clamped) differs from `win_q`:
  - Next edge: `win_q` latches the new value; `sum`, `fill` and `wr_ptr` clear to 0; `stu_sm_ready` drops.
  - An `ad_vld` in that cycle is dropped and produces no `sm_vld`.
  - Buffer contents are not cleared; the `fill` gating makes stale entries irrelevant.
- **W = 1 (`cfg_win = 0`):** pass-through with the pipeline latency. `old` is the previous sample, and `sm_vld` fires from the first sample.
- **`stu_sm_ready`:** level output, equal to `fill == W`.
- **Reset values:**
  - `sm_data` = 0, `sm_vld` = 0, `stu_sm_ready` = 0.
  - `sum`, `fill`, `wr_ptr` = 0; `win_q` = 0.
  - Buffer contents are not reset.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Pipeline strobes in flight are lost. After release, a full refill of W samples is required before the next `sm_vld`.

## Timing
- `ad_vld` at edge N: `sum`/`fill` updated at N+1; `sm_data` and `sm_vld` registered at N+2.
- Fixed latency: 2 cycles from `ad_vld` to `sm_vld`, with or without `SM_BASELINE_EN`.
- Throughput: one sample per cycle. No backpressure; the downstream stage always accepts.
- `sm_vld` is high for exactly one cycle per qualifying input. `sm_data` holds its value between strobes.
- `stu_sm_ready` updates at N+1, together with `fill`.
- The flush takes effect at the edge after `cfg_win` changes and has priority over `ad_vld` in the same cycle.

## Configuration
- **`SM_BASELINE_EN` defined:** output stage computes `sm_data = (mean >= cfg_base) ? mean - cfg_base : 0`. Result saturates at 0 and never wraps.
- **`SM_BASELINE_EN` undefined:** `sm_data = mean`. `cfg_base` is ignored; the port stays present so the top-level hookup is unchanged.
- Latency is identical in both builds.

## Test plan
- **Fill and constant input:** `cfg_win=2`, 8 back-to-back samples of 100 -> no `sm_vld` for the first 3; `sm_vld` 2 cycles after the 4th sample and every cycle after, `sm_data=100`; `stu_sm_ready=1` from the 4th sample on.
- **Ramp:** `cfg_win=2`, samples 0,4,8,12,16,20 with gaps -> `sm_data` = 6, 10, 14, one `sm_vld` per input.
- **Full scale and clamp:** `cfg_win=7` (clamps to 4), 20 samples of 0xFFFF -> first `sm_vld` on the 16th sample, `sm_data=0xFFFF`; no overflow.
- **Window change:**
  - Setup: `cfg_win=0` running at value 50.
  - Stimulus: switch to `cfg_win=1` with `ad_vld` asserted in the same cycle.
  - Expected: that sample is dropped and `stu_sm_ready` falls; the next 2 samples of 60 give one `sm_vld` with `sm_data=60`.
- **Baseline:** with `SM_BASELINE_EN`, `cfg_base=30`, `cfg_win=0`, samples 100 then 20 -> `sm_data` = 70 then 0.
- **Reset mid-operation:** `cfg_win=3`, 10 samples, then `rst_n` low for 1 cycle -> all outputs 0 immediately; 8 new samples are needed before the next `sm_vld`.
